resolved_bus_ctrl: RTL and testbench

Parametrised, clocked multi-driver net resolver: NCH channels drive one shared W-bit bus.
- Resolves per MODE: tri-state, wired-OR or wired-AND.
- Round-robin arbitration with bus lock.
- trireg-style charge retention with timed decay to a pull value.
- Saturating contention counter.
- Sits between the channel drivers and every bus consumer.
- Replaces ad-hoc multiply-assigned wor/wand/tri nets with a registered, verifiable resolver.

---
 rtl/bus_pkg.sv | 17 +
 rtl/resolved_bus_ctrl_if.sv | 29 ++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/resolved_bus_ctrl.sv | 109 ++++++++++
 tb/tb_resolved_bus_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Resolution modes shared by every resolved-bus block, plus the value a floating bus settles to.
// No timing; constants and a pure function only.
package bus_pkg;
  localparam int MODE_TRI  = 0;
  localparam int MODE_WOR  = 1;
  localparam int MODE_WAND = 2;
  localparam int MAX_W     = 64;

  // Wired modes float to their identity value; tri floats to its pull.
  function automatic logic [MAX_W-1:0] pull_value(input int mode, input logic [MAX_W-1:0] tri_pull);
    case (mode)
      MODE_WOR:  return '0;
      MODE_WAND: return '1;
      default:   return tri_pull;
    endcase
  endfunction
endpackage

// File: rtl/resolved_bus_ctrl_if.sv
// Channel-side request/drive signals and resolved-bus status of one shared bus.
// No logic; the master modport belongs to the drivers, the slave modport to the resolver.
interface resolved_bus_ctrl_if #(
  parameter int NCH   = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
);
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   drv_en;
  logic [NCH*W-1:0] drv_data;
  logic             clr_cnt;
  logic [NCH-1:0]   gnt;
  logic [W-1:0]     bus_q;
  logic             bus_valid;
  logic             bus_float;
  logic             decayed;
  logic             contention;
  logic [CNT_W-1:0] cont_cnt;

  modport master (
    output req, drv_en, drv_data, clr_cnt,
    input  gnt, bus_q, bus_valid, bus_float, decayed, contention, cont_cnt
  );

  modport slave (
    input  req, drv_en, drv_data, clr_cnt,
    output gnt, bus_q, bus_valid, bus_float, decayed, contention, cont_cnt
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with bus lock; one-hot grant registered, 1-cycle latency from req.
// A locked holder keeps the grant while its req stays high; others wait with no backpressure signal.
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           lock,
  input  logic [NCH-1:0] req,
  output logic [NCH-1:0] gnt
);
  localparam int PW = $clog2(NCH);

  logic [PW-1:0]  ptr;
  logic [PW-1:0]  ptr_nxt;
  logic [PW-1:0]  idx;
  logic [NCH-1:0] gnt_nxt;
  logic           hit;

  always_comb begin
    gnt_nxt = '0;
    ptr_nxt = ptr;
    idx     = '0;
    hit     = 1'b0;
    if (lock && |(gnt & req)) begin
      gnt_nxt = gnt;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        idx = PW'((int'(ptr) + i) % NCH);
        if (!hit && req[idx]) begin
          hit          = 1'b1;
          gnt_nxt[idx] = 1'b1;
          ptr_nxt      = PW'((int'(idx) + 1) % NCH);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt <= '0;
      ptr <= '0;
    end else begin
      gnt <= gnt_nxt;
      ptr <= ptr_nxt;
    end
  end
endmodule

// File: rtl/resolved_bus_ctrl.sv
// Registered multi-driver bus resolver (tri / wired-OR / wired-AND) with arbitration, retention and contention count.
// Latency 1 cycle from req/drv_en/drv_data; no backpressure, drivers are never stalled.
module resolved_bus_ctrl
  import bus_pkg::*;
#(
  parameter int             NCH      = 4,
  parameter int             W        = 8,
  parameter int             MODE     = 0,
  parameter int             HOLD_CYC = 8,
  parameter logic [W-1:0]   PULL_VAL = '0,
  parameter int             CNT_W    = 16
) (
  input logic               clk,
  input logic               rst,
  resolved_bus_ctrl_if.slave bus
);
  localparam logic [W-1:0]  PULL     = W'(pull_value(MODE, MAX_W'(PULL_VAL)));
  localparam int            HW       = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

  logic [NCH-1:0]   gnt;
  logic [NCH-1:0]   en;
  logic [W-1:0]     or_v, and_v, low_v, gnt_v, res_v;
  logic             low_set, multi, floating, gnt_en, cont_nxt;
  logic [W-1:0]     bus_r;
  logic             float_r, dec_r, cont_r;
  logic [HW-1:0]    hold_r;
  logic [CNT_W-1:0] cnt_r;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk  (clk),
    .rst  (rst),
    .lock (1'b1),
    .req  (bus.req),
    .gnt  (gnt)
  );

  assign en = bus.drv_en;

  always_comb begin
    or_v    = '0;
    and_v   = '1;
    low_v   = '0;
    gnt_v   = '0;
    low_set = 1'b0;
    multi   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt[i]) gnt_v = bus.drv_data[i*W +: W];
      if (en[i]) begin
        or_v  = or_v  | bus.drv_data[i*W +: W];
        and_v = and_v & bus.drv_data[i*W +: W];
        if (low_set) begin
          multi = 1'b1;
        end else begin
          low_v   = bus.drv_data[i*W +: W];
          low_set = 1'b1;
        end
      end
    end
  end

  assign floating = ~|en;
  assign gnt_en   = |(gnt & en);
  // Any enabled channel other than the holder is illegal in tri mode, as is more than one driver.
  assign cont_nxt = (MODE == MODE_TRI) && (multi || (|gnt && |(en & ~gnt)));

  always_comb begin
    case (MODE)
      MODE_WOR:  res_v = or_v;
      MODE_WAND: res_v = and_v;
      default:   res_v = gnt_en ? gnt_v : low_v;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_r   <= PULL;
      float_r <= 1'b1;
      dec_r   <= 1'b1;
      cont_r  <= 1'b0;
      cnt_r   <= '0;
      hold_r  <= '0;
    end else begin
      float_r <= floating;
      cont_r  <= cont_nxt;
      if (bus.clr_cnt) cnt_r <= '0;
      else if (cont_nxt && cnt_r != '1) cnt_r <= cnt_r + CNT_W'(1);
      // Tri bus keeps its charge for HOLD_CYC floating cycles, then decays to the pull value.
      if (!floating) begin
        bus_r  <= res_v;
        dec_r  <= 1'b0;
        hold_r <= '0;
      end else if (MODE != MODE_TRI || hold_r == HOLD_MAX) begin
        bus_r <= PULL;
        dec_r <= 1'b1;
      end else begin
        hold_r <= hold_r + HW'(1);
      end
    end
  end

  assign bus.gnt        = gnt;
  assign bus.bus_q      = bus_r;
  assign bus.bus_float  = float_r;
  assign bus.bus_valid  = ~float_r;
  assign bus.decayed    = dec_r;
  assign bus.contention = cont_r;
  assign bus.cont_cnt   = cnt_r;
endmodule

// File: tb/tb_resolved_bus_ctrl.sv
// Four resolver configurations share one stimulus stream and are checked against a behavioural model.
module tb_resolved_bus_ctrl;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0] req, drv_en;
  logic [7:0]     dat [NCH];
  logic [31:0]    drv_data;
  logic           clr;
  bit             chk_on = 1'b0;
  int             checks = 0;
  int             errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    drv_data = '0;
    for (int c = 0; c < NCH; c++) drv_data[c*8 +: 8] = dat[c];
  end

  resolved_bus_ctrl_if #(.NCH(4), .W(8), .CNT_W(16)) if0 ();
  resolved_bus_ctrl_if #(.NCH(4), .W(8), .CNT_W(16)) if1 ();
  resolved_bus_ctrl_if #(.NCH(4), .W(8), .CNT_W(16)) if2 ();
  resolved_bus_ctrl_if #(.NCH(4), .W(8), .CNT_W(4))  if3 ();

  assign if0.req = req; assign if0.drv_en = drv_en; assign if0.drv_data = drv_data; assign if0.clr_cnt = clr;
  assign if1.req = req; assign if1.drv_en = drv_en; assign if1.drv_data = drv_data; assign if1.clr_cnt = clr;
  assign if2.req = req; assign if2.drv_en = drv_en; assign if2.drv_data = drv_data; assign if2.clr_cnt = clr;
  assign if3.req = req; assign if3.drv_en = drv_en; assign if3.drv_data = drv_data; assign if3.clr_cnt = clr;

  resolved_bus_ctrl #(.NCH(4), .W(8), .MODE(0), .HOLD_CYC(8), .PULL_VAL(8'h00), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(if0));
  resolved_bus_ctrl #(.NCH(4), .W(8), .MODE(1), .HOLD_CYC(8), .PULL_VAL(8'h00), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(if1));
  resolved_bus_ctrl #(.NCH(4), .W(8), .MODE(2), .HOLD_CYC(8), .PULL_VAL(8'h00), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .bus(if2));
  resolved_bus_ctrl #(.NCH(4), .W(8), .MODE(0), .HOLD_CYC(3), .PULL_VAL(8'hFF), .CNT_W(4))  u3 (.clk(clk), .rst(rst), .bus(if3));

  logic [3:0]  o_gnt [4];
  logic [7:0]  o_bus [4];
  logic        o_val [4], o_flt [4], o_dec [4], o_con [4];
  logic [15:0] o_cnt [4];

  assign o_gnt[0] = if0.gnt; assign o_bus[0] = if0.bus_q; assign o_val[0] = if0.bus_valid; assign o_flt[0] = if0.bus_float;
  assign o_dec[0] = if0.decayed; assign o_con[0] = if0.contention; assign o_cnt[0] = if0.cont_cnt;
  assign o_gnt[1] = if1.gnt; assign o_bus[1] = if1.bus_q; assign o_val[1] = if1.bus_valid; assign o_flt[1] = if1.bus_float;
  assign o_dec[1] = if1.decayed; assign o_con[1] = if1.contention; assign o_cnt[1] = if1.cont_cnt;
  assign o_gnt[2] = if2.gnt; assign o_bus[2] = if2.bus_q; assign o_val[2] = if2.bus_valid; assign o_flt[2] = if2.bus_float;
  assign o_dec[2] = if2.decayed; assign o_con[2] = if2.contention; assign o_cnt[2] = if2.cont_cnt;
  assign o_gnt[3] = if3.gnt; assign o_bus[3] = if3.bus_q; assign o_val[3] = if3.bus_valid; assign o_flt[3] = if3.bus_float;
  assign o_dec[3] = if3.decayed; assign o_con[3] = if3.contention; assign o_cnt[3] = 16'(if3.cont_cnt);

  // Per-instance configuration: mode, hold cycles, settled floating value, counter ceiling.
  int         md [4] = '{0, 1, 2, 0};
  int         hd [4] = '{8, 8, 8, 3};
  logic [7:0] pl [4] = '{8'h00, 8'h00, 8'hFF, 8'hFF};
  int         cm [4] = '{65535, 65535, 65535, 15};

  // Model state: holder index (-1 idle), rotation start, last driven value, floating cycles since last drive.
  int         m_holder, m_ptr;
  logic [7:0] m_last [4];
  int         m_run  [4];
  bit         m_float[4], m_cont[4];
  int         m_cnt  [4];

  task automatic model_reset();
    m_holder = -1;
    m_ptr    = 0;
    for (int k = 0; k < 4; k++) begin
      m_last[k] = pl[k]; m_run[k] = 1 << 20; m_float[k] = 1'b1; m_cont[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step();
    int n_en;
    logic [7:0] orv, andv, low, trv;
    bit cont;
    n_en = 0; orv = 8'h00; andv = 8'hFF; low = 8'h00;
    for (int c = 0; c < NCH; c++) begin
      if (drv_en[c]) begin
        if (n_en == 0) low = dat[c];
        n_en++;
        orv  = orv | dat[c];
        andv = andv & dat[c];
      end
    end
    trv  = (m_holder >= 0 && drv_en[m_holder]) ? dat[m_holder] : low;
    cont = (n_en > 1) || (m_holder >= 0 && n_en == 1 && !drv_en[m_holder]);
    for (int k = 0; k < 4; k++) begin
      m_float[k] = (n_en == 0);
      if (n_en > 0) begin
        m_run[k]  = 0;
        m_last[k] = (md[k] == 0) ? trv : (md[k] == 1) ? orv : andv;
      end else if (m_run[k] < (1 << 20)) begin
        m_run[k]++;
      end
      m_cont[k] = (md[k] == 0) && cont;
      if (clr) m_cnt[k] = 0;
      else if (m_cont[k] && m_cnt[k] < cm[k]) m_cnt[k]++;
    end
    if (!(m_holder >= 0 && req[m_holder])) begin
      m_holder = -1;
      for (int s = 0; s < NCH; s++)
        if (m_holder < 0 && req[(m_ptr + s) % NCH]) m_holder = (m_ptr + s) % NCH;
      if (m_holder >= 0) m_ptr = (m_holder + 1) % NCH;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else     model_step();
  end

  function automatic bit exp_dec(int k);
    return m_float[k] && (md[k] != 0 || m_run[k] > hd[k]);
  endfunction

  function automatic logic [7:0] exp_bus(int k);
    return exp_dec(k) ? pl[k] : m_last[k];
  endfunction

  function automatic logic [3:0] exp_gnt();
    return (m_holder >= 0) ? 4'(1 << m_holder) : 4'h0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("gnt%0d", k),        64'(o_gnt[k]), 64'(exp_gnt()));
        chk($sformatf("bus_q%0d", k),      64'(o_bus[k]), 64'(exp_bus(k)));
        chk($sformatf("bus_valid%0d", k),  64'(o_val[k]), 64'(!m_float[k]));
        chk($sformatf("bus_float%0d", k),  64'(o_flt[k]), 64'(m_float[k]));
        chk($sformatf("decayed%0d", k),    64'(o_dec[k]), 64'(exp_dec(k)));
        chk($sformatf("contention%0d", k), 64'(o_con[k]), 64'(m_cont[k]));
        chk($sformatf("cont_cnt%0d", k),   64'(o_cnt[k]), 64'(m_cnt[k]));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req = '0; drv_en = '0; clr = 1'b0;
    for (int c = 0; c < NCH; c++) dat[c] = 8'h00;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    chk_on = 1'b1;
    tick();
    chk("rst_bus_q",     64'(if0.bus_q), 64'h00);
    chk("rst_bus_float", 64'(if0.bus_float), 64'd1);
    chk("rst_decayed",   64'(if0.decayed), 64'd1);
    chk("rst_gnt",       64'(if0.gnt), 64'h0);
    chk("rst_cont_cnt",  64'(if0.cont_cnt), 64'd0);
    chk("rst_wand_bus",  64'(if2.bus_q), 64'hFF);

    // Round-robin with lock.
    req = 4'hF; tick(); chk("arb_first", 64'(if0.gnt), 64'h1);
    tick();              chk("arb_lock",  64'(if0.gnt), 64'h1);
    req = 4'hE; tick(); chk("arb_rot1",  64'(if0.gnt), 64'h2);
    req = 4'hD; tick(); chk("arb_rot2",  64'(if0.gnt), 64'h4);
    req = 4'hB; tick(); chk("arb_rot3",  64'(if0.gnt), 64'h8);
    req = 4'h7; tick(); chk("arb_wrap",  64'(if0.gnt), 64'h1);

    // Retention and decay on channel 2.
    req = 4'h0; tick();
    req = 4'h4; tick(); chk("ret_gnt", 64'(if0.gnt), 64'h4);
    dat[2] = 8'hA5; drv_en = 4'h4; tick();
    chk("ret_drive", 64'(if0.bus_q), 64'hA5);
    drv_en = 4'h0;
    for (int i = 0; i < 8; i++) begin
      tick(); chk("ret_hold", 64'(if0.bus_q), 64'hA5);
    end
    tick();
    chk("ret_decay_q",   64'(if0.bus_q), 64'h00);
    chk("ret_decay_flg", 64'(if0.decayed), 64'd1);
    dat[2] = 8'h3C; drv_en = 4'h4; tick();
    chk("ret_redrive",     64'(if0.bus_q), 64'h3C);
    chk("ret_redrive_dec", 64'(if0.decayed), 64'd0);

    // Tri contention: ch1 granted, ch3 also driving.
    req = 4'h2; drv_en = 4'h0; tick();
    clr = 1'b1; tick(); clr = 1'b0;
    dat[1] = 8'h11; dat[3] = 8'h22; drv_en = 4'hA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("cont_bus",  64'(if0.bus_q), 64'h11);
      chk("cont_flag", 64'(if0.contention), 64'd1);
      chk("wor_bus",   64'(if1.bus_q), 64'h33);
      chk("wand_bus",  64'(if2.bus_q), 64'h00);
    end
    chk("cont_cnt3", 64'(if0.cont_cnt), 64'd3);
    drv_en = 4'h0; clr = 1'b1; tick(); clr = 1'b0;
    chk("cont_clr", 64'(if0.cont_cnt), 64'd0);

    // Wired modes.
    dat[0] = 8'h0F; dat[1] = 8'hF0; drv_en = 4'h3; tick();
    chk("wor_0f_f0",  64'(if1.bus_q), 64'hFF);
    chk("wor_nocont", 64'(if1.contention), 64'd0);
    chk("wand_0f_f0", 64'(if2.bus_q), 64'h00);
    drv_en = 4'h0; tick();
    chk("wand_float", 64'(if2.bus_q), 64'hFF);
    chk("wor_float",  64'(if1.bus_q), 64'h00);

    // Counter saturation with a 4-bit counter.
    clr = 1'b1; tick(); clr = 1'b0;
    drv_en = 4'hA;
    repeat (20) tick();
    chk("sat_cnt4",  64'(if3.cont_cnt), 64'd15);
    chk("sat_cnt16", 64'(if0.cont_cnt), 64'd20);

    // Asynchronous reset while ch1 holds the lock.
    chk("lock_before_rst", 64'(if0.gnt), 64'h2);
    #2 rst = 1'b1;
    #1 chk("async_rst_gnt", 64'(if0.gnt), 64'h0);
    chk("async_rst_cnt", 64'(if0.cont_cnt), 64'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    tick();

    // Randomized traffic with periodic quiet windows so retention expires.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(3) == 0) req[c] = ~req[c];
        dat[c] = 8'($urandom);
      end
      if ((cyc % 40) >= 28) drv_en = 4'h0;
      else begin
        case ($urandom_range(3))
          0:       drv_en = 4'h0;
          1:       drv_en = 4'($urandom);
          default: drv_en = (m_holder >= 0) ? 4'(1 << m_holder) : 4'h0;
        endcase
      end
      clr = ($urandom_range(15) == 0);
      tick();
    end

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
